dot_sched: RTL and testbench

//  Round-robin scheduler that shares one pipelined dot datapath among NREQ requesters.

---
 rtl/dot_sched.sv | 188 ++++++++++++++++++
 tb/tb_dot_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_sched.sv
// rtl/dot_sched.sv - round-robin scheduler sharing one pipelined dot datapath among requesters
// Optional feature macro: DOT_SCHED_PERF_EN adds saturating perf_jobs / perf_beats counters.
module dot_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_bias,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  input  logic [NREQ*W-1:0] req_d,
  output logic              dot_en,
  output logic [W-1:0]      dot_bias,
  output logic [W-1:0]      dot_a,
  output logic [W-1:0]      dot_b,
  output logic [W-1:0]      dot_c,
  output logic [W-1:0]      dot_d,
  input  logic [W-1:0]      dot_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_data
`ifdef DOT_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_jobs,
  output logic [15:0]       perf_beats
`endif
);

  // Drain counter only needs to hold LAT-1.
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IDW-1:0]  g;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  g_succ;
  logic [IDW-1:0]  pick;
  logic            pick_found;
  logic            first_beat;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            accept_last;
  logic            res_done;
  int              idx;

  // Handshake qualifiers shared by the FSM, datapath registers and counters.
  assign accept      = (state == ISSUE) && req_valid[g];
  assign accept_last = accept && req_last[g];
  assign res_done    = (state == RESP) && res_ready;
  assign g_succ      = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = IDW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found)       state_next = ISSUE;
      ISSUE:   if (accept_last)      state_next = DRAIN;
      DRAIN:   if (cnt == '0)        state_next = RESP;
      RESP:    if (res_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // Outputs: only ISSUE drives the datapath; a bubble issues zeros so the sum is unchanged.
  always_comb begin
    req_ready = '0;
    dot_en    = 1'b0;
    dot_bias  = '0;
    dot_a     = '0;
    dot_b     = '0;
    dot_c     = '0;
    dot_d     = '0;
    res_valid = (state == RESP);
    if (state == ISSUE) begin
      req_ready[g] = req_valid[g];
      dot_en       = 1'b1;
      if (req_valid[g]) begin
        dot_bias = first_beat ? req_bias[g*W +: W] : '0;
        dot_a    = req_a[g*W +: W];
        dot_b    = req_b[g*W +: W];
        dot_c    = req_c[g*W +: W];
        dot_d    = req_d[g*W +: W];
      end
    end
  end

  // Grant, first-beat flag, drain counter, result capture and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      g          <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b0;
      cnt        <= '0;
      res_data   <= '0;
      res_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            g          <= pick;
            first_beat <= 1'b1;
          end
        end
        ISSUE: begin
          if (accept) begin
            first_beat <= 1'b0;
            if (req_last[g]) begin
              cnt <= CW'(LAT - 1);
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            res_data <= dot_y;
            res_id   <= g;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (res_done) begin
            rr_ptr <= g_succ;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DOT_SCHED_PERF_EN
  // Saturating counters of completed jobs and accepted beats.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_jobs  <= '0;
      perf_beats <= '0;
    end else begin
      if (res_done && (perf_jobs != 16'hFFFF)) begin
        perf_jobs <= perf_jobs + 16'd1;
      end
      if (accept && (perf_beats != 16'hFFFF)) begin
        perf_beats <= perf_beats + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dot_sched.sv
// tb/tb_dot_sched.sv - self-checking bench for dot_sched with a dot datapath model and result scoreboard
module tb_dot_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_bias, req_a, req_b, req_c, req_d;
  logic              dot_en;
  logic [W-1:0]      dot_bias, dot_a, dot_b, dot_c, dot_d;
  logic [W-1:0]      dot_y;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_id;
  logic [W-1:0]      res_data;
`ifdef DOT_SCHED_PERF_EN
  logic [15:0]       perf_jobs, perf_beats;
`endif

  dot_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .req_bias(req_bias), .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .dot_en(dot_en), .dot_bias(dot_bias), .dot_a(dot_a), .dot_b(dot_b),
    .dot_c(dot_c), .dot_d(dot_d), .dot_y(dot_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data)
`ifdef DOT_SCHED_PERF_EN
    , .perf_jobs(perf_jobs), .perf_beats(perf_beats)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         gap;
    logic [7:0] bias, a, b, c, d;
    logic       last;
  } beat_t;

  beat_t       bq[NREQ][$];
  logic [7:0]  exp_q[NREQ][$];
  logic [7:0]  build_acc[NREQ];
  logic        build_first[NREQ];
  logic        tb_first[NREQ];
  logic [NREQ-1:0] pend;
  int          model_ptr;
  int          checks = 0;
  int          errors = 0;
  int          bubbles;
  int          stalls;
  int          res_hold;
  logic [1:0]  log_id[$];
  logic [7:0]  log_data[$];
  logic [7:0]  y_sh[LAT];
  logic [7:0]  dot_acc;
  logic        prev_en;
  logic        prev_hold;
  logic        after_hs;
  logic [7:0]  held_data;
  logic [1:0]  held_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Enqueue a beat and fold it into the job's expected result (bias from first beat only).
  task automatic add_beat(input int id, input int gap, input int bias, input int a,
                          input int b, input int c, input int d, input bit last);
    beat_t bt;
    logic [7:0] prod;
    bt.gap = gap; bt.bias = 8'(bias); bt.a = 8'(a); bt.b = 8'(b);
    bt.c = 8'(c); bt.d = 8'(d); bt.last = last;
    bq[id].push_back(bt);
    prod = 8'(a * b + c * d);
    if (build_first[id]) build_acc[id] = 8'(bias) + prod;
    else                 build_acc[id] = build_acc[id] + prod;
    build_first[id] = last;
    if (last) exp_q[id].push_back(build_acc[id]);
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      bq[i].delete();
      exp_q[i].delete();
      build_first[i] = 1'b1;
      tb_first[i]    = 1'b1;
    end
    pend      = '0;
    req_valid = '0;
    model_ptr = 0;
    prev_hold = 1'b0;
    after_hs  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock); #2;
    reset = 1'b1;
    flush();
    @(negedge clock); #2;
    reset = 1'b0;
  endtask

  function automatic bit busy();
    for (int i = 0; i < NREQ; i++)
      if (bq[i].size() != 0 || exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(input string name);
    int cyc = 0;
    while (busy() && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    chk({name, "_timeout"}, 32'(busy()), 32'd0);
    @(negedge clock); #2;
  endtask

  // Drive requester beats, model the dot datapath and check every cycle.
  initial begin : drive_check
    beat_t      bt;
    logic [7:0] cur;
    int         sel;
    for (int j = 0; j < LAT; j++) y_sh[j] = 8'd0;
    dot_acc = 8'd0;
    prev_en = 1'b0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && bq[i].size() > 0) begin
          bt = bq[i].pop_front();
          tb_first[i] = bt.last;
        end
      end
      pend = '0;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        if (bq[i].size() > 0) begin
          bt = bq[i][0];
          req_bias[i*W +: W] = bt.bias;
          req_a[i*W +: W]    = bt.a;
          req_b[i*W +: W]    = bt.b;
          req_c[i*W +: W]    = bt.c;
          req_d[i*W +: W]    = bt.d;
          req_last[i]        = bt.last;
          if (bt.gap > 0) begin
            bt.gap--;
            bq[i][0] = bt;
          end else begin
            req_valid[i] = 1'b1;
          end
        end
      end
      dot_y = y_sh[LAT-1];
      if (res_valid && res_hold > 0) begin
        res_ready = 1'b0;
        res_hold--;
      end else begin
        res_ready = 1'b1;
      end
      #1;
      if (!reset) begin
        chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
        chk("ready_subset_valid", 32'(req_ready & ~req_valid), 32'd0);
        if (after_hs) chk("ready_after_resp", 32'(req_ready), 32'd0);
        after_hs = 1'b0;
        if (res_valid) begin
          chk("ready_in_resp", 32'(req_ready), 32'd0);
          chk("en_in_resp", 32'(dot_en), 32'd0);
        end
        if (!dot_en)
          chk("idle_operands", 32'(dot_bias | dot_a | dot_b | dot_c | dot_d), 32'd0);
        else if (req_ready == '0) begin
          chk("bubble_operands", 32'(dot_bias | dot_a | dot_b | dot_c | dot_d), 32'd0);
          bubbles++;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) begin
            chk("beat_en", 32'(dot_en), 32'd1);
            chk("beat_bias", 32'(dot_bias), tb_first[i] ? 32'(req_bias[i*W +: W]) : 32'd0);
            chk("beat_ops", {dot_a, dot_b, dot_c, dot_d},
                {req_a[i*W +: W], req_b[i*W +: W], req_c[i*W +: W], req_d[i*W +: W]});
          end
        end
        if (prev_hold) begin
          chk("res_valid_held", 32'(res_valid), 32'd1);
          chk("res_stable", {22'd0, res_id, res_data}, {22'd0, held_id, held_data});
        end
        held_id   = res_id;
        held_data = res_data;
        prev_hold = res_valid && !res_ready;
        if (res_valid && !res_ready) stalls++;
        if (res_valid && res_ready) begin
          sel = -1;
          for (int k = 0; k < NREQ; k++) begin
            if (sel < 0 && exp_q[(model_ptr + k) % NREQ].size() > 0) sel = (model_ptr + k) % NREQ;
          end
          if (sel < 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            chk("res_id", 32'(res_id), 32'(sel));
            chk("res_data", 32'(res_data), 32'(exp_q[sel].pop_front()));
            model_ptr = (sel + 1) % NREQ;
          end
          log_id.push_back(res_id);
          log_data.push_back(res_data);
          after_hs = 1'b1;
        end
        pend = req_valid & req_ready;
      end
      if (dot_en) begin
        cur = (prev_en ? dot_acc : 8'd0) + dot_bias + dot_a * dot_b + dot_c * dot_d;
        dot_acc = cur;
      end
      prev_en = dot_en;
      for (int j = LAT - 1; j > 0; j--) y_sh[j] = y_sh[j-1];
      y_sh[0] = dot_acc;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] v_nogap;
    reset = 1'b1; req_valid = '0; req_last = '0; res_ready = 1'b1; res_hold = 0;
    req_bias = '0; req_a = '0; req_b = '0; req_c = '0; req_d = '0; dot_y = '0;
    bubbles = 0; stalls = 0;
    flush();
    do_reset();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_dot_en", 32'(dot_en), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res", {22'd0, res_id, res_data}, 32'd0);

    // 1: single beat -2*3 from req0
    add_beat(0, 0, 0, -2, 3, 0, 0, 1);
    wait_done("t1");
    chk("t1_data", 32'(log_data[$]), 32'h0FA);
    chk("t1_id", 32'(log_id[$]), 32'd0);

    // 2: two beats from req2, second bias ignored
    add_beat(2, 0, 3, 1, 2, 7, 2, 0);
    add_beat(2, 0, 9, -3, 4, 0, 0, 1);
    wait_done("t2");
    chk("t2_data", 32'(log_data[$]), 32'd7);
    chk("t2_id", 32'(log_id[$]), 32'd2);

    // 3: same job from req1 without and with a 2-cycle gap
    bubbles = 0;
    add_beat(1, 0, 5, 2, 3, 1, 4, 0);
    add_beat(1, 0, 7, -1, 6, 2, 2, 0);
    add_beat(1, 0, 7, 3, 3, 0, 0, 1);
    add_beat(1, 0, 5, 2, 3, 1, 4, 0);
    add_beat(1, 2, 7, -1, 6, 2, 2, 0);
    add_beat(1, 0, 7, 3, 3, 0, 0, 1);
    wait_done("t3");
    v_nogap = log_data[log_data.size() - 2];
    chk("t3_nogap", 32'(v_nogap), 32'h16);
    chk("t3_gap_equal", 32'(log_data[$]), 32'(v_nogap));
    chk("t3_bubbles", 32'(bubbles), 32'd2);

    // 4: all requesters valid -> 0,1,2,3,0
    do_reset();
`ifdef DOT_SCHED_PERF_EN
    chk("perf_rst", {perf_jobs, perf_beats}, 32'd0);
`endif
    for (int i = 0; i < NREQ; i++) add_beat(i, 0, i + 1, i + 1, 2, 1, -1, 1);
    add_beat(0, 0, 10, 1, 1, 0, 0, 1);
    wait_done("t4");
    chk("t4_order", {24'd0, log_id[$-4], log_id[$-3], log_id[$-2], log_id[$-1], log_id[$]},
        {24'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
    chk("t4_data_r3", 32'(log_data[$-1]), 32'd11);
    chk("t4_data_r0b", 32'(log_data[$]), 32'd11);
`ifdef DOT_SCHED_PERF_EN
    chk("perf_jobs", 32'(perf_jobs), 32'd5);
    chk("perf_beats", 32'(perf_beats), 32'd5);
`endif

    // 5: consumer stalls 5 cycles while req3 waits
    stalls = 0;
    res_hold = 5;
    add_beat(2, 0, 1, 4, 4, 0, 0, 1);
    add_beat(3, 0, 2, 1, 1, 0, 0, 1);
    wait_done("t5");
    chk("t5_stalls", 32'(stalls), 32'd5);
    chk("t5_order", {28'd0, log_id[$-1], log_id[$]}, {28'd0, 2'd2, 2'd3});
    chk("t5_data", {16'd0, log_data[$-1], log_data[$]}, {16'd0, 8'd17, 8'd3});

    // 6: reset during ISSUE, then a clean job from req0
    add_beat(0, 0, 1, 1, 1, 0, 0, 0);
    add_beat(0, 10, 0, 2, 2, 0, 0, 1);
    repeat (4) @(negedge clock);
    do_reset();
    chk("t6_dot_en", 32'(dot_en), 32'd0);
    chk("t6_res_valid", 32'(res_valid), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
`ifdef DOT_SCHED_PERF_EN
    chk("t6_perf_rst", {perf_jobs, perf_beats}, 32'd0);
`endif
    add_beat(0, 0, 0, 5, 5, 0, 0, 1);
    wait_done("t6");
    chk("t6_data", 32'(log_data[$]), 32'h19);
    chk("t6_id", 32'(log_id[$]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
